// File: rtl/mips_defs.sv
// Shared MIPS front-end definitions.
//   MIPS_NOP      : all-zero instruction word (sll $0,$0,0), driven as a bubble
//   PC_W/INSTR_W  : widths of the program counter and instruction word
//   fetch_entry_t : one {pc, instr} pair as carried from fetch to decode
package mips_defs;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] MIPS_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/dffare.sv
// Generic W-bit register with synchronous reset and enable.
//   clk : clock
//   r   : synchronous active-high clear (dominates en)
//   en  : load enable
//   d   : next value
//   q   : registered value
module dffare #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         r,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (r) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_queue_store.sv
// DEPTH-entry storage for the IF/ID queue: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset; the control
// logic masks any entry that is not currently valid.
//   clk   : clock
//   we    : write enable
//   waddr : write address (write pointer)
//   wdata : {pc, instr} to store
//   raddr : read address (read pointer)
//   rdata : {pc, instr} at raddr, combinational
module if_id_queue_store
  import mips_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  fetch_entry_t       wdata,
  input  logic [PTR_W-1:0]   raddr,
  output fetch_entry_t       rdata
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Decoupling queue between instruction fetch and decode.
// Holds up to DEPTH {pc, instr} pairs in order and hands them to decode over a
// valid/ready handshake. A redirect flush discards everything so decode never
// sees wrong-path instructions; when empty, decode sees pc=0 and a NOP.
//   clk, rst              : clock, synchronous active-high reset
//   enq_valid/pc/instr    : entry offered by fetch
//   enq_ready             : queue accepts an entry (use as fetch enable)
//   flush                 : branch/jump redirect, discard all entries
//   deq_ready             : decode consumes the head entry
//   deq_valid/pc/instr    : head entry (0 / NOP when not valid)
//   count                 : occupancy 0..DEPTH
module if_id_queue
  import mips_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enq_valid,
  input  logic [PC_W-1:0]    enq_pc,
  input  logic [INSTR_W-1:0] enq_instr,
  output logic               enq_ready,
  input  logic               flush,
  input  logic               deq_ready,
  output logic               deq_valid,
  output logic [PC_W-1:0]    deq_pc,
  output logic [INSTR_W-1:0] deq_instr,
  output logic [PTR_W:0]     count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             clear;
  logic             enq_fire;
  logic             deq_fire;
  logic [PTR_W:0]   count_next;
  fetch_entry_t     wr_entry;
  fetch_entry_t     head;

  // Readiness depends only on registered occupancy (and rst), so a full queue
  // refuses an entry even in a cycle where decode drains the head.
  assign enq_ready = !rst && (count != FULL_COUNT);
  assign deq_valid = (count != '0);
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;

  // Reset and flush both collapse the queue; the clear input of each register
  // dominates its enable, so any fire in a flush cycle is ignored.
  assign clear = rst || flush;

  // Power-of-two depth: natural pointer overflow is the modulo wrap.
  dffare #(.W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .r   (clear),
    .en  (enq_fire),
    .d   (wr_ptr + PTR_W'(1)),
    .q   (wr_ptr)
  );

  dffare #(.W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .r   (clear),
    .en  (deq_fire),
    .d   (rd_ptr + PTR_W'(1)),
    .q   (rd_ptr)
  );

  // Occupancy changes only when exactly one side fires.
  assign count_next = enq_fire ? (count + (PTR_W+1)'(1)) : (count - (PTR_W+1)'(1));

  dffare #(.W(PTR_W+1)) u_count (
    .clk (clk),
    .r   (clear),
    .en  (enq_fire ^ deq_fire),
    .d   (count_next),
    .q   (count)
  );

  assign wr_entry.pc    = enq_pc;
  assign wr_entry.instr = enq_instr;

  if_id_queue_store #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_store (
    .clk   (clk),
    .we    (enq_fire && !flush),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Stale storage is never exposed: mask to 0 / NOP when empty.
  assign deq_pc    = deq_valid ? head.pc    : '0;
  assign deq_instr = deq_valid ? head.instr : MIPS_NOP;

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk;
  logic        rst;
  logic        enq_valid;
  logic [31:0] enq_pc;
  logic [31:0] enq_instr;
  logic        enq_ready;
  logic        flush;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;
  logic [PTR_W:0] count;

  int errors = 0;
  int checks = 0;

  // Reference model: an in-order list of {pc, instr} entries.
  logic [63:0] mq[$];

  if_id_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .enq_valid (enq_valid),
    .enq_pc    (enq_pc),
    .enq_instr (enq_instr),
    .enq_ready (enq_ready),
    .flush     (flush),
    .deq_ready (deq_ready),
    .deq_valid (deq_valid),
    .deq_pc    (deq_pc),
    .deq_instr (deq_instr),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model before
  // the edge, then advance the model by the queue's rules.
  task automatic step(input logic r, input logic ev, input logic [31:0] pc,
                      input logic fl, input logic dr);
    logic [31:0] ins;
    logic        m_ready;
    logic        m_valid;
    logic [63:0] head;
    ins       = $urandom;
    rst       = r;
    enq_valid = ev;
    enq_pc    = pc;
    enq_instr = ins;
    flush     = fl;
    deq_ready = dr;
    #1;
    m_ready = !r && (mq.size() < DEPTH);
    m_valid = (mq.size() != 0);
    head    = m_valid ? mq[0] : 64'h0;
    check("enq_ready", {63'h0, enq_ready}, {63'h0, m_ready});
    check("deq_valid", {63'h0, deq_valid}, {63'h0, m_valid});
    check("deq_pc",    {32'h0, deq_pc},    {32'h0, head[63:32]});
    check("deq_instr", {32'h0, deq_instr}, {32'h0, head[31:0]});
    check("count",     {61'h0, count},     64'(mq.size()));
    @(posedge clk);
    if (r) begin
      $display("t=%0t rst", $time);
      mq.delete();
    end else if (fl) begin
      $display("t=%0t flush (dropped %0d)", $time, mq.size());
      mq.delete();
    end else begin
      if (m_valid && dr) begin
        $display("t=%0t deq pc=%h instr=%h", $time, head[63:32], head[31:0]);
        void'(mq.pop_front());
      end
      if (m_ready && ev) begin
        $display("t=%0t enq pc=%h instr=%h", $time, pc, ins);
        mq.push_back({pc, ins});
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; enq_valid = 1'b0; enq_pc = '0; enq_instr = '0;
    flush = 1'b0; deq_ready = 1'b0;
    @(posedge clk); #1;

    // Reset held two cycles, then released.
    step(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("rst_count", {61'h0, count}, 64'h0);
    check("rst_deq_instr", {32'h0, deq_instr}, 64'h0);
    idle();

    // Fill with no consumer: fifth offer must be refused.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'(i * 4), 1'b0, 1'b0);
    check("fill_count", {61'h0, count}, 64'd4);
    check("fill_enq_ready", {63'h0, enq_ready}, 64'd0);
    check("fill_head_pc", {32'h0, deq_pc}, 64'h0);

    // Stream from empty across the pointer wrap.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b1);
    check("stream_count", {61'h0, count}, 64'd1);
    check("stream_last_pc", {32'h0, deq_pc}, 64'h128);

    // Flush with simultaneous enq and deq: everything dropped, pc 0x40 lost.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h20 + 32'(i * 4), 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
    check("flush_count", {61'h0, count}, 64'd0);
    check("flush_deq_valid", {63'h0, deq_valid}, 64'd0);
    check("flush_deq_instr", {32'h0, deq_instr}, 64'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);   // flush while empty
    check("flush_empty_count", {61'h0, count}, 64'd0);

    // Full queue with a consumer: enq refused this cycle, accepted next.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h310, 1'b0, 1'b1);
    check("full_deq_count", {61'h0, count}, 64'd3);
    step(1'b0, 1'b1, 32'h310, 1'b0, 1'b0);
    check("full_refill_count", {61'h0, count}, 64'd4);
    check("full_head_pc", {32'h0, deq_pc}, 64'h304);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Reset in the middle of operation.
    step(1'b0, 1'b1, 32'h50, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h54, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("midrst_count", {61'h0, count}, 64'd0);
    check("midrst_deq_valid", {63'h0, deq_valid}, 64'd0);
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
    check("midrst_first_pc", {32'h0, deq_pc}, 64'h200);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(49) == 0), 1'($urandom), 32'h1000 + 32'(i * 4),
           ($urandom_range(15) == 0), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
